// File: rtl/seg_pkg.sv
// Shared types and glyph tables for the seven-segment display controller.
// Glyphs are active-low, bit 0 = segment a ... bit 6 = segment g.
package seg_pkg;

    localparam int NUM_DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LOAD  = 2'd2
    } conv_state_t;

    localparam logic [6:0] GLYPH_0     = 7'h40;
    localparam logic [6:0] GLYPH_1     = 7'h79;
    localparam logic [6:0] GLYPH_2     = 7'h24;
    localparam logic [6:0] GLYPH_3     = 7'h30;
    localparam logic [6:0] GLYPH_4     = 7'h19;
    localparam logic [6:0] GLYPH_5     = 7'h12;
    localparam logic [6:0] GLYPH_6     = 7'h02;
    localparam logic [6:0] GLYPH_7     = 7'h78;
    localparam logic [6:0] GLYPH_8     = 7'h00;
    localparam logic [6:0] GLYPH_9     = 7'h10;
    localparam logic [6:0] GLYPH_BLANK = 7'h7F;
    localparam logic [6:0] GLYPH_A     = 7'h08;
    localparam logic [6:0] GLYPH_B     = 7'h03;
    localparam logic [6:0] GLYPH_O     = 7'h23;
    localparam logic [6:0] GLYPH_R     = 7'h2F;

    localparam logic [3:0] LET_BLANK = 4'd0;
    localparam logic [3:0] LET_A     = 4'd1;
    localparam logic [3:0] LET_B     = 4'd2;
    localparam logic [3:0] LET_O     = 4'd3;
    localparam logic [3:0] LET_R     = 4'd4;

    function automatic logic [6:0] digit_glyph(input logic [3:0] d);
        case (d)
            4'd0:    return GLYPH_0;
            4'd1:    return GLYPH_1;
            4'd2:    return GLYPH_2;
            4'd3:    return GLYPH_3;
            4'd4:    return GLYPH_4;
            4'd5:    return GLYPH_5;
            4'd6:    return GLYPH_6;
            4'd7:    return GLYPH_7;
            4'd8:    return GLYPH_8;
            4'd9:    return GLYPH_9;
            default: return GLYPH_BLANK;
        endcase
    endfunction

    function automatic logic [6:0] letter_glyph(input logic [3:0] code);
        case (code)
            LET_A:   return GLYPH_A;
            LET_B:   return GLYPH_B;
            LET_O:   return GLYPH_O;
            LET_R:   return GLYPH_R;
            default: return GLYPH_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts a changed binary input to 3 BCD nibbles.
// Latency: 10 cycles from capture to done pulse (9 shifts + load).
// No backpressure: input changes while busy are picked up once back in IDLE.
module bin2bcd_seq
    import seg_pkg::*;
#(
    parameter int DATA_W = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    output logic [11:0]       bcd,
    output logic              busy,
    output logic              done
);

    conv_state_t       state;
    logic [DATA_W-1:0] last_val;
    logic [DATA_W-1:0] sr;
    logic [3:0]        shift_cnt;
    logic [11:0]       bcd_adj;

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 3; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            last_val  <= '0;
            sr        <= '0;
            bcd       <= '0;
            shift_cnt <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (din != last_val) begin
                        last_val  <= din;
                        sr        <= din;
                        bcd       <= '0;
                        shift_cnt <= '0;
                        busy      <= 1'b1;
                        state     <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // adjust-then-shift across the joined {bcd, sr} register
                    {bcd, sr} <= {bcd_adj, sr} << 1;
                    shift_cnt <= shift_cnt + 4'd1;
                    if (shift_cnt == 4'(DATA_W - 1)) begin
                        state <= ST_LOAD;
                        done  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/seg_display_ctrl.sv
// 4-digit multiplexed 7-seg driver: decimal result on digits 2..0, mode glyph on 3.
// Latency: display updates 10 cycles after a new value is captured; an/seg lag idx by 1.
// No backpressure; SEG_LEADING_ZERO_BLANK_EN blanks leading zeros of hundreds/tens.
module seg_display_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV = 50000,
    parameter int DATA_W      = 9
) (
    input  logic                  Clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     Out_with_carry,
    input  logic [3:0]            Letters,
    output logic [NUM_DIGITS-1:0] an,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic                  conv_busy
);

    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam int IDX_W = $clog2(NUM_DIGITS);

    logic [11:0]      bcd;
    logic             conv_done;
    logic [3:0]       dig_ones, dig_tens, dig_hund;
    logic [6:0]       letter_reg;
    logic [6:0]       slot_glyph;
    logic [PRE_W-1:0] presc;
    logic [IDX_W-1:0] idx;

    bin2bcd_seq #(.DATA_W(DATA_W)) u_bin2bcd (
        .clk   (Clk),
        .reset (reset),
        .din   (Out_with_carry),
        .bcd   (bcd),
        .busy  (conv_busy),
        .done  (conv_done)
    );

    always_comb begin
        slot_glyph = GLYPH_BLANK;
        case (idx)
            2'd0: slot_glyph = digit_glyph(dig_ones);
`ifdef SEG_LEADING_ZERO_BLANK_EN
            2'd1: slot_glyph = (dig_hund == 4'd0 && dig_tens == 4'd0) ? GLYPH_BLANK
                                                                      : digit_glyph(dig_tens);
            2'd2: slot_glyph = (dig_hund == 4'd0) ? GLYPH_BLANK : digit_glyph(dig_hund);
`else
            2'd1: slot_glyph = digit_glyph(dig_tens);
            2'd2: slot_glyph = digit_glyph(dig_hund);
`endif
            default: slot_glyph = letter_reg;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            dig_ones   <= '0;
            dig_tens   <= '0;
            dig_hund   <= '0;
            letter_reg <= GLYPH_BLANK;
            presc      <= '0;
            idx        <= '0;
            an         <= '1;
            seg        <= GLYPH_BLANK;
        end else begin
            // digits swap together only on a finished conversion
            if (conv_done) begin
                dig_ones <= bcd[3:0];
                dig_tens <= bcd[7:4];
                dig_hund <= bcd[11:8];
            end
            letter_reg <= letter_glyph(Letters);
            if (presc == PRE_W'(REFRESH_DIV - 1)) begin
                presc <= '0;
                idx   <= idx + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            an  <= ~(NUM_DIGITS'(1) << idx);
            seg <= slot_glyph;
        end
    end

    assign dp = 1'b1;

endmodule

// File: tb/tb_seg_display_ctrl.sv
// Bench for seg_display_ctrl: directed scenarios plus random inputs, every cycle
// compared against a countdown/division reference model.
module tb_seg_display_ctrl;

    localparam int R = 4;
`ifdef SEG_LEADING_ZERO_BLANK_EN
    localparam logic [6:0] HZ = 7'h7F;
    localparam bit LZB = 1'b1;
`else
    localparam logic [6:0] HZ = 7'h40;
    localparam bit LZB = 1'b0;
`endif

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic [8:0] Out_with_carry = '0;
    logic [3:0] Letters = '0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       conv_busy;

    int checks = 0;
    int errors = 0;

    seg_display_ctrl #(.REFRESH_DIV(R), .DATA_W(9)) dut (
        .Clk            (Clk),
        .reset          (reset),
        .Out_with_carry (Out_with_carry),
        .Letters        (Letters),
        .an             (an),
        .seg            (seg),
        .dp             (dp),
        .conv_busy      (conv_busy)
    );

    always #5 Clk = ~Clk;

    logic [6:0] dig_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    function automatic logic [6:0] letter_of(input logic [3:0] code);
        case (code)
            4'd1:    return 7'h08;
            4'd2:    return 7'h03;
            4'd3:    return 7'h23;
            4'd4:    return 7'h2F;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [6:0] expect_glyph(input int slot, input int v, input logic [6:0] g);
        case (slot)
            0:       return dig_tab[v % 10];
            1:       return (LZB && v < 10)  ? 7'h7F : dig_tab[(v / 10) % 10];
            2:       return (LZB && v < 100) ? 7'h7F : dig_tab[v / 100];
            default: return g;
        endcase
    endfunction

    // Reference model: a value change starts a 10-cycle countdown, display takes it at zero.
    int         m_last, m_pend, m_cnt, m_disp, m_slot, m_tick;
    logic [6:0] m_glyph, m_seg;
    logic [3:0] m_an;
    logic       m_busy;

    always @(posedge Clk) begin
        if (reset) begin
            m_last = 0; m_pend = 0; m_cnt = 0; m_disp = 0; m_slot = 0; m_tick = 0;
            m_glyph = 7'h7F; m_seg = 7'h7F; m_an = 4'hF; m_busy = 1'b0;
        end else begin
            m_an  = ~(4'b0001 << m_slot);
            m_seg = expect_glyph(m_slot, m_disp, m_glyph);
            m_glyph = letter_of(Letters);
            if (m_cnt == 0) begin
                if (int'(Out_with_carry) != m_last) begin
                    m_last = int'(Out_with_carry);
                    m_pend = m_last;
                    m_cnt  = 10;
                end
            end else begin
                m_cnt--;
                if (m_cnt == 0) m_disp = m_pend;
            end
            m_busy = (m_cnt != 0);
            m_tick++;
            if (m_tick == R) begin
                m_tick = 0;
                m_slot = (m_slot + 1) % 4;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge Clk);
        chk("an", 32'(an), 32'(m_an));
        chk("seg", 32'(seg), 32'(m_seg));
        chk("dp", 32'(dp), 32'd1);
        chk("busy", 32'(conv_busy), 32'(m_busy));
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic busy_run(output int len);
        int waited = 0;
        len = 0;
        while (conv_busy !== 1'b1 && waited < 20) begin step(); waited++; end
        while (conv_busy === 1'b1 && len < 30) begin len++; step(); end
    endtask

    task automatic scan(output logic [27:0] s);
        s = 'x;
        repeat (4 * R + 1) begin
            step();
            for (int i = 0; i < 4; i++)
                if (an === ~(4'b0001 << i)) s[7*i +: 7] = seg;
        end
    endtask

    initial begin
        int          len;
        logic [27:0] s;
        logic [21:0] pat;
        logic        seen;

        // reset held for 5 cycles, then released
        reset = 1'b1;
        cycles(5);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_busy", 32'(conv_busy), 32'd0);
        reset = 1'b0;
        step();
        chk("rel_an", 32'(an), 32'hE);
        chk("rel_seg", 32'(seg), 32'h40);

        // input 0 matches last_val: no conversion
        seen = 1'b0;
        repeat (12) begin step(); if (conv_busy !== 1'b0) seen = 1'b1; end
        chk("zero_no_conv", 32'(seen), 32'd0);

        Out_with_carry = 9'd20; Letters = 4'd4;
        busy_run(len);
        chk("busy_len_20", len, 10);
        scan(s);
        chk("disp_20", 32'(s), 32'({7'h2F, HZ, 7'h24, 7'h40}));

        Out_with_carry = 9'h100;
        busy_run(len);
        chk("busy_len_256", len, 10);
        scan(s);
        chk("disp_256", 32'(s), 32'({7'h2F, 7'h24, 7'h12, 7'h02}));

        Out_with_carry = 9'd511; Letters = 4'd1;
        busy_run(len);
        scan(s);
        chk("disp_511", 32'(s), 32'({7'h08, 7'h12, 7'h79, 7'h79}));

        // change mid-conversion: 20 shown at E+10, 10 captured at E+11, shown at E+21
        Out_with_carry = 9'd20;
        pat = '0;
        for (int k = 0; k < 22; k++) begin
            step();
            pat[k] = conv_busy;
            if (k == 3) Out_with_carry = 9'd10;
        end
        chk("busy_restart_pattern", 32'(pat), 32'h1FFBFF);
        scan(s);
        chk("disp_10", 32'(s), 32'({7'h08, HZ, 7'h79, 7'h40}));

        Out_with_carry = 9'd7;
        busy_run(len);
        scan(s);
        chk("disp_7", 32'(s), 32'({7'h08, HZ, HZ, 7'h78}));

        // reset at E+5 of a conversion
        Out_with_carry = 9'd300;
        cycles(5);
        reset = 1'b1;
        step();
        chk("midrst_busy", 32'(conv_busy), 32'd0);
        chk("midrst_an", 32'(an), 32'hF);
        chk("midrst_seg", 32'(seg), 32'h7F);
        reset = 1'b0;
        step();
        chk("postrst_seg", 32'(seg), 32'h40);
        chk("postrst_busy", 32'(conv_busy), 32'd1);
        busy_run(len);
        chk("busy_len_300", len, 10);
        scan(s);
        chk("disp_300", 32'(s), 32'({7'h08, 7'h30, 7'h40, 7'h40}));

        // random values, letter codes, hold times and occasional reset pulses
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) Out_with_carry = 9'($urandom_range(0, 511));
            Letters = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 11) == 0) begin
                reset = 1'b1;
                step();
                reset = 1'b0;
            end
            cycles(int'($urandom_range(1, 24)));
        end
        cycles(30);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
